// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// A start in IDLE runs to a one-cycle done pulse; the result is registered on entry to DONE.
package ops_pkg;
    typedef enum logic [2:0] {
        MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
        MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM    = 3'd6, MD_REMU   = 3'd7
    } md_op;
endpackage

module muldiv_unit
    import ops_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit SUPPORT_W = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            op_w,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam bit W_EN = SUPPORT_W && (XLEN == 64);
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_n;

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    md_op              op_i, op_q;
    logic              w_eff, is_div, is_rem, a_sgn, b_sgn, neg_a, neg_b;
    logic              div0, ovf, illegal, special, accept;
    logic [XLEN-1:0]   ea, eb, ma, mb, min_v, spec_res;
    logic              w_q, neg_q, nega_q;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   x;
    logic [2*XLEN-1:0] y, acc, p_s;
    logic [XLEN:0]     r_sh, r_sub;
    logic [XLEN-1:0]   q_s, r_s, fix_res;

    // Operand decode, magnitudes and the short-circuit results, all evaluated in IDLE.
    always_comb begin
        op_i    = md_op'(op);
        w_eff   = W_EN && op_w;
        is_div  = op[2];
        is_rem  = op[2] && op[1];
        a_sgn   = op_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        b_sgn   = op_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        ea      = w_eff ? (a_sgn ? sx32(a[31:0]) : XLEN'(a[31:0])) : a;
        eb      = w_eff ? (b_sgn ? sx32(b[31:0]) : XLEN'(b[31:0])) : b;
        neg_a   = a_sgn && ea[XLEN-1];
        neg_b   = b_sgn && eb[XLEN-1];
        ma      = neg_a ? -ea : ea;
        mb      = neg_b ? -eb : eb;
        min_v   = w_eff ? sx32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div0    = is_div && (eb == '0);
        ovf     = (op_i == MD_DIV || op_i == MD_REM) && (ea == min_v) && (eb == '1);
        illegal = w_eff && !is_div && (op_i != MD_MUL);
        special = div0 || ovf || illegal;
        if (illegal)   spec_res = '0;
        else if (div0) spec_res = is_rem ? (w_eff ? sx32(a[31:0]) : a) : '1;
        else           spec_res = is_rem ? '0 : ea;
    end

    assign accept = (state == IDLE) && start && !kill;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_n;

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_n = special ? DONE : CALC;
            end
            CALC: begin
                if (kill)                  state_n = IDLE;
                else if (count == CW'(1))  state_n = FIXUP;
            end
            FIXUP:   state_n = kill ? IDLE : DONE;
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Restoring divide step and final sign fix / result selection.
    always_comb begin
        r_sh    = {acc[XLEN-1:0], x[XLEN-1]};
        r_sub   = r_sh - {1'b0, y[XLEN-1:0]};
        p_s     = neg_q ? -acc : acc;
        q_s     = neg_q ? -x : x;
        r_s     = nega_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        fix_res = r_s;
        case (op_q)
            MD_MUL:                       fix_res = p_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = p_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = q_s;
            default:                      fix_res = r_s;
        endcase
        if (w_q) fix_res = sx32(fix_res[31:0]);
    end

    // x: multiplier (shifts right) or dividend/quotient (shifts left).
    // y: multiplicand (shifts left) or divisor. acc: product or partial remainder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= MD_MUL;
            w_q    <= 1'b0;
            neg_q  <= 1'b0;
            nega_q <= 1'b0;
            count  <= '0;
            x      <= '0;
            y      <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= op_i;
                    w_q    <= w_eff;
                    neg_q  <= neg_a ^ neg_b;
                    nega_q <= neg_a;
                    count  <= w_eff ? CW'(32) : CW'(XLEN);
                    acc    <= '0;
                    if (is_div) begin
                        // word dividends are left-aligned so the next bit is always x[XLEN-1]
                        x <= w_eff ? (ma << (XLEN - 32)) : ma;
                        y <= (2*XLEN)'(mb);
                    end else begin
                        x <= mb;
                        y <= (2*XLEN)'(ma);
                    end
                    if (special) result <= spec_res;
                end
                CALC: begin
                    count <= count - CW'(1);
                    if (op_q[2]) begin
                        x   <= {x[XLEN-2:0], ~r_sub[XLEN]};
                        acc <= {{(XLEN-1){1'b0}}, (r_sub[XLEN] ? r_sh : r_sub)};
                    end else begin
                        if (x[0]) acc <= acc + y;
                        x <= x >> 1;
                        y <= y << 1;
                    end
                end
                FIXUP: if (!kill) result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import ops_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, start, op_w, kill, busy, done;
    logic [2:0]  op;
    logic [63:0] a, b, result;

    int          cyc = 0, n_tests = 0, n_fail = 0, t_iss = 0, id_n = 0;
    logic [63:0] last_res = '0;

    typedef struct {
        int          id;
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    muldiv_unit #(.XLEN(64), .SUPPORT_W(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .op_w(op_w),
        .a(a), .b(b), .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle t is the one whose closing edge samples start; done must appear in cycle t+lat.
    task automatic issue(input md_op o, input logic w, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] exp, input int lat, input bit push, input bit k = 1'b0);
        @(negedge clk);
        start = 1'b1; op = o; op_w = w; a = x; b = y; kill = k;
        t_iss = cyc + 1;
        if (push) begin
            sb.push_back('{id_n, exp, t_iss + lat});
            last_res = exp;
        end
        id_n++;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op = 3'($urandom); op_w = 1'($urandom);
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        @(negedge clk);
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done in cycle %0d expected no done", cyc + 1);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("op%0d_result", e.id), result, e.res);
                    check($sformatf("op%0d_done_cycle", e.id), 64'(cyc + 1), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; op_w = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        reset_n = 1'b1;

        // MUL 7 * -3 with busy window t+1..t+66
        issue(MD_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 1'b1);
        bad = 0;
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk);
            if (busy !== (k <= 66)) bad++;
        end
        check("mul_busy_window_errors", 64'(bad), 64'd0);

        issue(MD_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b1);
        wait_idle(100);
        issue(MD_MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b1);
        wait_idle(100);
        issue(MD_MULH, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 66, 1'b1);
        wait_idle(100);

        // divide by zero, then a start in DONE (ignored), then one accepted right after
        issue(MD_DIV, 1'b0, 64'd5, 64'd0, '1, 1, 1'b1);
        @(negedge clk);
        start = 1'b1; op = MD_MUL; op_w = 1'b0; a = 64'd2; b = 64'd3;
        @(posedge clk); #1;
        start = 1'b0;
        issue(MD_REM, 1'b0, 64'd5, 64'd0, 64'd5, 1, 1'b1);
        wait_idle(10);
        issue(MD_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1'b1);
        wait_idle(10);
        issue(MD_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1'b1);
        wait_idle(10);

        // word ops
        issue(MD_DIV, 1'b1, 64'h1234_5678_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34, 1'b1);
        wait_idle(100);
        issue(MD_REMU, 1'b1, 64'd7, 64'd3, 64'd1, 34, 1'b1);
        wait_idle(100);
        issue(MD_MUL, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b1);
        wait_idle(100);
        issue(MD_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 34, 1'b1);
        wait_idle(100);
        issue(MD_MULHU, 1'b1, 64'd5, 64'd6, 64'd0, 1, 1'b1);
        wait_idle(10);
        issue(MD_DIVU, 1'b1, 64'd9, 64'h0000_0001_0000_0000, '1, 1, 1'b1);
        wait_idle(10);

        // signed divide with a start pulse during CALC that must be ignored
        issue(MD_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1; op = MD_MUL; op_w = 1'b0; a = 64'd3; b = 64'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(100);
        issue(MD_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66, 1'b1);
        wait_idle(100);
        issue(MD_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b1);
        wait_idle(100);
        issue(MD_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, 1'b1);
        wait_idle(100);

        // kill mid-CALC: idle next cycle, no done, result untouched
        issue(MD_DIVU, 1'b0, 64'd1000, 64'd3, 64'd0, 66, 1'b0);
        repeat (20) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_result_held", result, last_res);

        // kill together with start in IDLE: request refused
        issue(MD_DIV, 1'b0, 64'd5, 64'd0, '1, 1, 1'b0, 1'b1);
        @(negedge clk);
        check("kill_start_busy", 64'(busy), 64'd0);

        // kill in DONE does not suppress done
        issue(MD_REMU, 1'b0, 64'd9, 64'd0, 64'd9, 1, 1'b1);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        wait_idle(10);

        // asynchronous reset mid-operation
        issue(MD_MUL, 1'b0, 64'd123, 64'd456, 64'd0, 66, 1'b0);
        repeat (30) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_result", result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_res = '0;
        issue(MD_MUL, 1'b0, 64'd123, 64'd456, 64'd56088, 66, 1'b1);

        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("result_hold_after_done", result, last_res);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
